// File: rtl/pe_pkg.sv
// Shared definitions for the PE systolic chain: FSM encoding, default
// chain geometry and the datapath fixed-point format.
package pe_pkg;

  localparam int unsigned PE_NUM_PE_DEF    = 9;
  localparam int unsigned PE_CNT_WIDTH_DEF = 16;

  // PE datapath fixed-point format: fractional bits of the Q-format.
  localparam int unsigned PE_Q_FRAC = 13;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/pe_token_pipe.sv
// Valid/last token shift register mirroring the PE chain occupancy.
// All stages advance together on adv_i; a stalled chain holds every token.
module pe_token_pipe
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE = PE_NUM_PE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              v_i,
  input  logic              last_i,
  output logic [NUM_PE-1:0] v_o,
  output logic              last_o
);

  logic [NUM_PE-1:0] v_q;
  logic [NUM_PE-1:0] last_q;

  // Shift valid and last flags one stage per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      last_q <= '0;
    end else if (adv_i) begin
      v_q    <= {v_q[NUM_PE-2:0], v_i};
      last_q <= {last_q[NUM_PE-2:0], last_i};
    end
  end

  assign v_o    = v_q;
  assign last_o = last_q[NUM_PE-1];

endmodule

// File: rtl/pe_chain_ctrl.sv
// Sequencer for a 1-D systolic PE chain: accepts a job, meters input
// vectors into stage 0, drives per-stage set_reg enables, freezes the
// chain under downstream backpressure and flags the final result.
// Optional: define PE_CTRL_PERF_EN to add stall_cnt / bubble_cnt counters.
module pe_chain_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE    = PE_NUM_PE_DEF,
  parameter int unsigned CNT_WIDTH = PE_CNT_WIDTH_DEF,
  parameter int unsigned POOLING   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_out,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_PE-1:0]    set_reg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 cfg_pool_o
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 busy_q, done_q;

  logic [NUM_PE-1:0]    v;
  logic                 last_tok;
  logic                 adv;
  logic                 acc;
  logic                 in_last;
  logic                 out_fire;
  logic                 start_fire;

  // Chain handshake: the whole chain advances unless the output is blocked.
  assign adv        = ~out_valid | out_ready;
  assign in_ready   = (state_q == ST_RUN) & adv;
  assign acc        = in_valid & in_ready;
  assign in_last    = acc & (in_cnt_q == (num_q - CNT_WIDTH'(1)));
  assign out_fire   = out_valid & out_ready;
  assign start_fire = (state_q == ST_IDLE) & start;

  // Stage 0 writes on a real acceptance; later stages only behind a valid token.
  assign set_reg    = {v[NUM_PE-2:0] & {(NUM_PE-1){adv}}, acc};

  assign out_valid  = v[NUM_PE-1];
  assign out_last   = last_tok;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_pool_o = (POOLING != 0);

  pe_token_pipe #(
    .NUM_PE (NUM_PE)
  ) u_token_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (adv),
    .v_i    (acc),
    .last_i (in_last),
    .v_o    (v),
    .last_o (last_tok)
  );

  // Next-state and counter logic for the job sequencer.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (acc) begin
      in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
    end
    if (out_fire) begin
      out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_out;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (num_out == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc && (in_cnt_d == num_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_fire && (out_cnt_d == num_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      busy_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
    end
  end

`ifdef PE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  // Saturating stall/bubble counters, cleared at job start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (start_fire) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (busy_q && out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'(1);
      end
      if ((state_q == ST_RUN) && in_ready && !in_valid && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 32'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Self-checking bench for pe_chain_ctrl: directed scenarios plus randomized
// jobs, checked against a token-age model of the chain.
module tb_pe_chain_ctrl;

  localparam int unsigned NUM_PE    = 9;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned VW        = NUM_PE + 5;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [CNT_WIDTH-1:0] num_out;
  logic                 busy;
  logic                 done;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_PE-1:0]    set_reg;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 cfg_pool_o;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]          stall_cnt;
  logic [31:0]          bubble_cnt;
`endif

  pe_chain_ctrl #(
    .NUM_PE    (NUM_PE),
    .CNT_WIDTH (CNT_WIDTH),
    .POOLING   (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_out    (num_out),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .set_reg    (set_reg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .cfg_pool_o (cfg_pool_o)
`ifdef PE_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests_run;
  int unsigned tests_failed;
  int          cyc;

  // Reference model: a job is active from start until its last output is
  // taken; each in-flight token carries its job index and the number of
  // chain advances it has seen (age k means it sits in stage k-1).
  bit m_active;
  bit m_done_pend;
  int m_num;
  int m_in_cnt;
  int m_out_cnt;
  int tok_age[$];
  int tok_id[$];

  // Per-cycle snapshots: {busy, done, in_ready, out_valid, out_last, set_reg}.
  logic [VW-1:0] o_vec;
  logic [VW-1:0] e_vec;
  logic          o_ov, o_last, o_done, o_busy, o_rdy;
  logic [NUM_PE-1:0] o_set;
  bit            o_fire;
  int            stage_cnt[NUM_PE];

  task automatic model_reset();
    m_active    = 1'b0;
    m_done_pend = 1'b0;
    m_num       = 0;
    m_in_cnt    = 0;
    m_out_cnt   = 0;
    tok_age.delete();
    tok_id.delete();
  endtask

  // Drive one cycle, snapshot DUT and model expectations, then advance the model.
  task automatic step(input bit iv, input bit ordy, input bit st, input int nout);
    bit e_ov, e_last, adv, e_rdy, e_acc, idle;
    logic [NUM_PE-1:0] e_set;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    start     = st;
    num_out   = CNT_WIDTH'(nout);
    #1;
    cyc++;
    e_ov   = (tok_age.size() > 0) && (tok_age[0] == NUM_PE);
    e_last = e_ov && (tok_id[0] == m_num - 1);
    adv    = !e_ov || ordy;
    e_rdy  = m_active && (m_in_cnt < m_num) && adv;
    e_acc  = iv && e_rdy;
    e_set  = '0;
    e_set[0] = e_acc;
    if (adv) begin
      foreach (tok_age[k]) if (tok_age[k] < NUM_PE) e_set[tok_age[k]] = 1'b1;
    end
    e_vec  = {m_active, m_done_pend, e_rdy, e_ov, e_last, e_set};
    o_busy = busy; o_done = done; o_rdy = in_ready; o_ov = out_valid;
    o_last = out_last; o_set = set_reg;
    o_vec  = {busy, done, in_ready, out_valid, out_last, set_reg};
    o_fire = out_valid && ordy;
    for (int k = 0; k < NUM_PE; k++) if (set_reg[k] === 1'b1) stage_cnt[k]++;
    // Clock edge as seen by the model.
    idle        = !m_active && !m_done_pend;
    m_done_pend = 1'b0;
    if (e_ov && ordy) begin
      void'(tok_age.pop_front());
      void'(tok_id.pop_front());
      m_out_cnt++;
      if (m_out_cnt == m_num) begin
        m_active    = 1'b0;
        m_done_pend = 1'b1;
      end
    end
    if (adv) foreach (tok_age[k]) tok_age[k]++;
    if (e_acc) begin
      tok_age.push_back(1);
      tok_id.push_back(m_in_cnt);
      m_in_cnt++;
    end
    if (idle && st) begin
      if (nout == 0) m_done_pend = 1'b1;
      else begin
        m_active = 1'b1; m_num = nout; m_in_cnt = 0; m_out_cnt = 0;
      end
    end
  endtask

  task automatic clear_stage_cnt();
    for (int k = 0; k < NUM_PE; k++) stage_cnt[k] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; num_out = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests_run++; if (set_reg !== '0) begin tests_failed++; $display("FAIL reset_set_reg got %b exp 0", set_reg); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    tests_run++; if (cfg_pool_o !== 1'b0) begin tests_failed++; $display("FAIL cfg_pool got %b exp 0", cfg_pool_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int rdy_n, set0_n, fires, first_acc, first_ov, last_idx, last_fire_cyc, done_cyc;
    rdy_n = 0; set0_n = 0; fires = 0; first_acc = -1; first_ov = -1;
    last_idx = -1; last_fire_cyc = -1; done_cyc = -1;
    step(1, 1, 1, 4);
    for (int i = 0; i < 80; i++) begin
      step(1, 1, 0, 0);
      tests_run++;
      if (o_vec !== e_vec) begin tests_failed++; $display("FAIL basic_proto cyc=%0d got %b exp %b", cyc, o_vec, e_vec); end
      if (o_rdy) rdy_n++;
      if (o_set[0]) begin set0_n++; if (first_acc < 0) first_acc = cyc; end
      if (o_ov && first_ov < 0) first_ov = cyc;
      if (o_fire) begin fires++; last_fire_cyc = cyc; if (o_last) last_idx = fires; end
      if (o_done) begin done_cyc = cyc; break; end
    end
    tests_run++; if (rdy_n != 4) begin tests_failed++; $display("FAIL basic_in_ready_cycles got %0d exp 4", rdy_n); end
    tests_run++; if (set0_n != 4) begin tests_failed++; $display("FAIL basic_set0_pulses got %0d exp 4", set0_n); end
    tests_run++; if (first_ov - first_acc != 9) begin tests_failed++; $display("FAIL basic_latency got %0d exp 9", first_ov - first_acc); end
    tests_run++; if (fires != 4) begin tests_failed++; $display("FAIL basic_outputs got %0d exp 4", fires); end
    tests_run++; if (last_idx != 4) begin tests_failed++; $display("FAIL basic_last_index got %0d exp 4", last_idx); end
    tests_run++;
    if (done_cyc < 0 || done_cyc != last_fire_cyc + 1) begin
      tests_failed++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, last_fire_cyc + 1);
    end
  endtask

  task automatic test_zero();
    int st_cyc, done_n, done_cyc, busy_n, set_n;
    done_n = 0; done_cyc = -1; busy_n = 0; set_n = 0;
    step(1, 1, 1, 0);
    st_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      tests_run++;
      if (o_vec !== e_vec) begin tests_failed++; $display("FAIL zero_proto cyc=%0d got %b exp %b", cyc, o_vec, e_vec); end
      if (o_done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (o_busy) busy_n++;
      if (o_set != '0) set_n++;
    end
    tests_run++; if (done_cyc != st_cyc + 1 || done_n != 1) begin tests_failed++; $display("FAIL zero_done got cyc %0d n %0d exp cyc %0d n 1", done_cyc, done_n, st_cyc + 1); end
    tests_run++; if (busy_n != 0) begin tests_failed++; $display("FAIL zero_busy got %0d exp 0", busy_n); end
    tests_run++; if (set_n != 0) begin tests_failed++; $display("FAIL zero_set_reg got %0d exp 0", set_n); end
  endtask

  task automatic test_stall();
    int fires, last_idx, bad_hold;
    bit seen_done, ordy;
    fires = 0; last_idx = -1; bad_hold = 0; seen_done = 0;
    step(1, 1, 1, 5);
    for (int i = 1; i < 100; i++) begin
      ordy = !(i >= 10 && i <= 14);
      step(1, ordy, 0, 0);
      tests_run++;
      if (o_vec !== e_vec) begin tests_failed++; $display("FAIL stall_proto cyc=%0d got %b exp %b", cyc, o_vec, e_vec); end
      if (!ordy && (o_rdy !== 1'b0 || o_set !== '0 || o_ov !== 1'b1 || o_last !== 1'b0)) bad_hold++;
      if (o_fire) begin fires++; if (o_last) last_idx = fires; end
      if (o_done) begin seen_done = 1; break; end
    end
    tests_run++; if (bad_hold != 0) begin tests_failed++; $display("FAIL stall_freeze got %0d bad cycles exp 0", bad_hold); end
    tests_run++; if (fires != 5 || !seen_done) begin tests_failed++; $display("FAIL stall_outputs got %0d done %0d exp 5 done 1", fires, seen_done); end
    tests_run++; if (last_idx != 5) begin tests_failed++; $display("FAIL stall_last_index got %0d exp 5", last_idx); end
  endtask

  task automatic test_bubbles();
    int fires, last_idx, bad_stage;
    bit seen_done;
    fires = 0; last_idx = -1; bad_stage = -1; seen_done = 0;
    clear_stage_cnt();
    step(0, 1, 1, 6);
    for (int i = 1; i < 100; i++) begin
      step(i % 2 == 1, 1, 0, 0);
      tests_run++;
      if (o_vec !== e_vec) begin tests_failed++; $display("FAIL bubble_proto cyc=%0d got %b exp %b", cyc, o_vec, e_vec); end
      if (o_fire) begin fires++; if (o_last) last_idx = fires; end
      if (o_done) begin seen_done = 1; break; end
    end
    for (int k = 0; k < NUM_PE; k++) if (stage_cnt[k] != 6 && bad_stage < 0) bad_stage = k;
    tests_run++; if (bad_stage >= 0) begin tests_failed++; $display("FAIL bubble_stage_writes stage %0d got %0d exp 6", bad_stage, stage_cnt[bad_stage]); end
    tests_run++; if (fires != 6 || !seen_done) begin tests_failed++; $display("FAIL bubble_outputs got %0d done %0d exp 6 done 1", fires, seen_done); end
    tests_run++; if (last_idx != 6) begin tests_failed++; $display("FAIL bubble_last_index got %0d exp 6", last_idx); end
  endtask

  task automatic test_start_ignored();
    int fires, last_idx;
    bit seen_done;
    fires = 0; last_idx = -1; seen_done = 0;
    step(1, 1, 1, 5);
    for (int i = 1; i < 100; i++) begin
      step(1, 1, (i == 2) || (i == 8), int'($urandom_range(1, 20)));
      tests_run++;
      if (o_vec !== e_vec) begin tests_failed++; $display("FAIL ignore_proto cyc=%0d got %b exp %b", cyc, o_vec, e_vec); end
      if (o_fire) begin fires++; if (o_last) last_idx = fires; end
      if (o_done) begin seen_done = 1; break; end
    end
    tests_run++; if (fires != 5 || !seen_done) begin tests_failed++; $display("FAIL ignore_outputs got %0d done %0d exp 5 done 1", fires, seen_done); end
    tests_run++; if (last_idx != 5) begin tests_failed++; $display("FAIL ignore_last_index got %0d exp 5", last_idx); end
  endtask

  task automatic test_reset_mid_drain();
    int fires, last_idx;
    bit seen_done, reached;
    fires = 0; last_idx = -1; seen_done = 0; reached = 0;
    step(1, 1, 1, 4);
    for (int i = 0; i < 60; i++) begin
      step(1, 1, 0, 0);
      if (m_out_cnt == 2) begin reached = 1; break; end
    end
    tests_run++; if (!reached || tok_age.size() != 2) begin tests_failed++; $display("FAIL rst_setup got in_flight %0d exp 2", tok_age.size()); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, in_ready, out_valid, out_last, set_reg} !== '0) begin
      tests_failed++; $display("FAIL rst_async got %b exp 0", {busy, done, in_ready, out_valid, out_last, set_reg});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 1, 3);
    for (int i = 0; i < 60; i++) begin
      step(1, 1, 0, 0);
      tests_run++;
      if (o_vec !== e_vec) begin tests_failed++; $display("FAIL rst_proto cyc=%0d got %b exp %b", cyc, o_vec, e_vec); end
      if (o_fire) begin fires++; if (o_last) last_idx = fires; end
      if (o_done) begin seen_done = 1; break; end
    end
    tests_run++; if (fires != 3 || !seen_done) begin tests_failed++; $display("FAIL rst_outputs got %0d done %0d exp 3 done 1", fires, seen_done); end
    tests_run++; if (last_idx != 3) begin tests_failed++; $display("FAIL rst_last_index got %0d exp 3", last_idx); end
  endtask

  task automatic test_random();
    int num, fires, last_idx, bad_stage;
    bit seen_done;
    for (int j = 0; j < 4; j++) begin
      num = int'($urandom_range(1, 12));
      fires = 0; last_idx = -1; bad_stage = -1; seen_done = 0;
      clear_stage_cnt();
      step(0, 1, 1, num);
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, int'($urandom_range(0, 30)));
        tests_run++;
        if (o_vec !== e_vec) begin tests_failed++; $display("FAIL rand_proto job=%0d cyc=%0d got %b exp %b", j, cyc, o_vec, e_vec); end
        if (o_fire) begin fires++; if (o_last) last_idx = fires; end
        if (o_done) begin seen_done = 1; break; end
      end
      for (int k = 0; k < NUM_PE; k++) if (stage_cnt[k] != num && bad_stage < 0) bad_stage = k;
      tests_run++; if (bad_stage >= 0) begin tests_failed++; $display("FAIL rand_stage_writes job=%0d stage %0d got %0d exp %0d", j, bad_stage, stage_cnt[bad_stage], num); end
      tests_run++; if (fires != num || !seen_done) begin tests_failed++; $display("FAIL rand_outputs job=%0d got %0d done %0d exp %0d done 1", j, fires, seen_done, num); end
      tests_run++; if (last_idx != num) begin tests_failed++; $display("FAIL rand_last_index job=%0d got %0d exp %0d", j, last_idx, num); end
      step(0, 1, 0, 0);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0;
    clear_stage_cnt();
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_bubbles();
    test_start_ignored();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
